// File: rtl/spongent_ctrl_if.sv
// Bundle of requester-side and core-side signals for spongent_ctrl.
// slave = controller view, master = environment (requesters plus hash core).
interface spongent_ctrl_if #(
  parameter int N = 256,
  parameter int r = 16
);
  logic [1:0]     req_valid;
  logic [2*r-1:0] req_data;
  logic [1:0]     req_last;
  logic [1:0]     req_ready;
  logic [1:0]     dig_valid;
  logic [1:0]     dig_ready;
  logic [N-1:0]   digest;
  logic           error;
  logic           core_rst;
  logic [r-1:0]   core_data_input;
  logic           core_data_ready;
  logic           core_start_hash;
  logic           core_busy;
  logic           core_end_hash;
  logic [N-1:0]   core_digest;

  modport slave (
    input  req_valid, req_data, req_last, dig_ready,
           core_busy, core_end_hash, core_digest,
    output req_ready, dig_valid, digest, error,
           core_rst, core_data_input, core_data_ready, core_start_hash
  );

  modport master (
    output req_valid, req_data, req_last, dig_ready,
           core_busy, core_end_hash, core_digest,
    input  req_ready, dig_valid, digest, error,
           core_rst, core_data_input, core_data_ready, core_start_hash
  );
endinterface

// File: rtl/spongent_ctrl.sv
// Two-requester round-robin front end for a SPONGENT hash core.
// Optional watchdog on absorb/finalize waits: define SPONGENT_CTRL_TIMEOUT_EN.
module spongent_ctrl #(
  parameter int N              = 256,
  parameter int r              = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst,
  spongent_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    CORE_RST, IDLE, FEED, WAIT_ABS, FINAL, DELIVER
  } state_t;

  state_t         state_reg, state_next;
  logic           rst_cnt_reg, rst_cnt_next;
  logic           ptr_reg, ptr_next;
  logic           grant_reg, grant_next;
  logic           last_reg, last_next;
  logic           first_reg, first_next;
  logic [r-1:0]   data_reg, data_next;
  logic           data_rdy_reg, data_rdy_next;
  logic [N-1:0]   digest_reg, digest_next;
  logic           feed_acc;
  logic           abort;
  logic [1:0]     sel_oh;
  logic [r-1:0]   req_word [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_word
      assign req_word[gi] = bus.req_data[gi*r +: r];
    end
  endgenerate

`ifdef SPONGENT_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_reg, tmo_next;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= CORE_RST;
      rst_cnt_reg  <= 1'b0;
      ptr_reg      <= 1'b0;
      grant_reg    <= 1'b0;
      last_reg     <= 1'b0;
      first_reg    <= 1'b0;
      data_reg     <= '0;
      data_rdy_reg <= 1'b0;
      digest_reg   <= '0;
`ifdef SPONGENT_CTRL_TIMEOUT_EN
      tmo_reg      <= '0;
`endif
    end else begin
      state_reg    <= state_next;
      rst_cnt_reg  <= rst_cnt_next;
      ptr_reg      <= ptr_next;
      grant_reg    <= grant_next;
      last_reg     <= last_next;
      first_reg    <= first_next;
      data_reg     <= data_next;
      data_rdy_reg <= data_rdy_next;
      digest_reg   <= digest_next;
`ifdef SPONGENT_CTRL_TIMEOUT_EN
      tmo_reg      <= tmo_next;
`endif
    end
  end

  always_comb begin
    state_next    = state_reg;
    rst_cnt_next  = rst_cnt_reg;
    ptr_next      = ptr_reg;
    grant_next    = grant_reg;
    last_next     = last_reg;
    first_next    = first_reg;
    data_next     = data_reg;
    data_rdy_next = 1'b0;
    digest_next   = digest_reg;
    feed_acc      = 1'b0;
    abort         = 1'b0;
`ifdef SPONGENT_CTRL_TIMEOUT_EN
    tmo_next      = tmo_reg;
`endif
    case (state_reg)
      CORE_RST: begin
        rst_cnt_next = ~rst_cnt_reg;
        if (rst_cnt_reg) state_next = IDLE;
      end
      IDLE: begin
        if (|bus.req_valid && !bus.core_busy) begin
          grant_next = bus.req_valid[ptr_reg] ? ptr_reg : ~ptr_reg;
          state_next = FEED;
        end
      end
      FEED: begin
        if (bus.req_valid[grant_reg] && !bus.core_busy) begin
          feed_acc      = 1'b1;
          data_next     = req_word[grant_reg];
          data_rdy_next = 1'b1;
          last_next     = bus.req_last[grant_reg];
          first_next    = 1'b1;
          state_next    = WAIT_ABS;
`ifdef SPONGENT_CTRL_TIMEOUT_EN
          tmo_next      = '0;
`endif
        end
      end
      WAIT_ABS: begin
        // The core only sees core_data_ready during this first cycle, so its busy is stale here.
        if (first_reg) begin
          first_next = 1'b0;
        end else if (!bus.core_busy) begin
          state_next = last_reg ? FINAL : FEED;
`ifdef SPONGENT_CTRL_TIMEOUT_EN
          tmo_next   = '0;
`endif
        end
      end
      FINAL: begin
        if (bus.core_end_hash && !bus.core_busy) begin
          digest_next = bus.core_digest;
          state_next  = DELIVER;
        end
      end
      DELIVER: begin
        if (bus.dig_ready[grant_reg]) begin
          ptr_next     = ~ptr_reg;
          rst_cnt_next = 1'b0;
          state_next   = CORE_RST;
        end
      end
      default: state_next = CORE_RST;
    endcase
`ifdef SPONGENT_CTRL_TIMEOUT_EN
    // A normal exit in the same cycle as expiry wins over the abort.
    if ((state_reg == WAIT_ABS || state_reg == FINAL) && state_next == state_reg) begin
      if (tmo_reg == TW'(TIMEOUT_CYCLES - 1)) begin
        abort        = 1'b1;
        ptr_next     = ~ptr_reg;
        rst_cnt_next = 1'b0;
        state_next   = CORE_RST;
      end else begin
        tmo_next = tmo_reg + TW'(1);
      end
    end
`endif
  end

  assign sel_oh              = grant_reg ? 2'b10 : 2'b01;
  assign bus.req_ready       = feed_acc ? sel_oh : 2'b00;
  assign bus.dig_valid       = (state_reg == DELIVER) ? sel_oh : 2'b00;
  assign bus.digest          = digest_reg;
  assign bus.core_rst        = (state_reg == CORE_RST);
  assign bus.core_data_input = data_reg;
  assign bus.core_data_ready = data_rdy_reg;
  assign bus.core_start_hash = (state_reg == FINAL);
`ifdef SPONGENT_CTRL_TIMEOUT_EN
  assign bus.error           = abort;
`else
  assign bus.error           = 1'b0;
`endif

endmodule

// File: tb/tb_spongent_ctrl.sv
// Directed bench for spongent_ctrl: arbitration, absorb/finalize/deliver path, reset, watchdog.
module tb_spongent_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  spongent_ctrl_if #(.N(256), .r(16)) bus ();

  spongent_ctrl #(.N(256), .r(16), .TIMEOUT_CYCLES(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [1:0] oh(input int g);
    return (g == 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic wait_ready(input int g);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (bus.req_ready[g]) got = 1'b1;
      else tick();
    end
    check("req_ready_seen", got, 1'b1);
    check("other_ready", bus.req_ready[g^1], 1'b0);
  endtask

  task automatic feed_word(input int g, input logic [15:0] word, input logic last, input int busy_n);
    bus.req_valid[g]        = 1'b1;
    bus.req_data[g*16 +: 16] = word;
    bus.req_last[g]         = last;
    settle();
    wait_ready(g);
    tick();
    bus.req_valid[g] = 1'b0;
    bus.req_last[g]  = 1'b0;
    bus.core_busy    = 1'b1;
    settle();
    check("core_data_ready", bus.core_data_ready, 1'b1);
    check("core_data_input", bus.core_data_input, word);
    for (int i = 0; i < busy_n; i++) begin
      tick();
      check("data_held", bus.core_data_input, word);
      check("data_ready_pulse", bus.core_data_ready, 1'b0);
    end
    bus.core_busy = 1'b0;
    tick();
    check("start_after_absorb", bus.core_start_hash, last);
    $display("word g=%0d data=%h last=%0d", g, word, last);
  endtask

  task automatic finish_hash(input int g, input logic [255:0] dval, input int end_delay, input int hold_n);
    for (int i = 0; i < end_delay; i++) begin
      bus.core_busy     = 1'b1;
      bus.core_end_hash = (i == 0);
      tick();
      check("start_held", bus.core_start_hash, 1'b1);
    end
    bus.core_busy     = 1'b0;
    bus.core_end_hash = 1'b1;
    bus.core_digest   = dval;
    tick();
    bus.core_end_hash = 1'b0;
    bus.core_digest   = ~dval;
    settle();
    check("digest", bus.digest, dval);
    check("dig_valid", bus.dig_valid, oh(g));
    check("start_cleared", bus.core_start_hash, 1'b0);
    for (int i = 0; i < hold_n; i++) begin
      tick();
      check("dig_valid_hold", bus.dig_valid, oh(g));
      check("no_core_rst", bus.core_rst, 1'b0);
      check("no_ready_deliver", bus.req_ready, 2'b00);
    end
    bus.dig_ready[g] = 1'b1;
    tick();
    bus.dig_ready[g] = 1'b0;
    settle();
    check("dig_valid_clr", bus.dig_valid, 2'b00);
    check("core_rst_1", bus.core_rst, 1'b1);
    tick();
    check("core_rst_2", bus.core_rst, 1'b1);
    tick();
    check("core_rst_end", bus.core_rst, 1'b0);
    $display("digest g=%0d value=%h", g, dval);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.req_valid = '0; bus.req_data = '0; bus.req_last = '0; bus.dig_ready = '0;
    bus.core_busy = 1'b0; bus.core_end_hash = 1'b0; bus.core_digest = '0;

    // Reset state
    tick(); tick();
    check("rst_core_rst", bus.core_rst, 1'b1);
    check("rst_req_ready", bus.req_ready, 2'b00);
    check("rst_dig_valid", bus.dig_valid, 2'b00);
    check("rst_digest", bus.digest, '0);
    check("rst_cdi", bus.core_data_input, 16'h0);
    check("rst_cdr", bus.core_data_ready, 1'b0);
    check("rst_start", bus.core_start_hash, 1'b0);
    check("rst_error", bus.error, 1'b0);
    rst = 1'b1;
    tick();
    check("core_rst_c1", bus.core_rst, 1'b1);
    tick();
    check("core_rst_idle", bus.core_rst, 1'b0);
    $display("reset done");

    // Both requesters pending, pointer at 0: three-word message from requester 0
    bus.req_valid[1] = 1'b1; bus.req_data[31:16] = 16'h1111; bus.req_last[1] = 1'b1;
    feed_word(0, 16'h0101, 1'b0, 2);
    feed_word(0, 16'h0202, 1'b0, 1);
    feed_word(0, 16'h0303, 1'b1, 3);
    finish_hash(0, {8{32'hDEAD_0001}}, 3, 10);

    // Pointer now 1: requester 1 wins despite requester 0 also valid
    bus.req_valid[0] = 1'b1; bus.req_data[15:0] = 16'h2222; bus.req_last[0] = 1'b1;
    feed_word(1, 16'h1111, 1'b1, 1);
    finish_hash(1, {8{32'hBEEF_0002}}, 1, 0);

    // Third simultaneous request returns to requester 0; single word
    bus.req_valid[1] = 1'b1; bus.req_last[1] = 1'b1;
    feed_word(0, 16'hABCD, 1'b1, 4);
    finish_hash(0, {8{32'hCAFE_0003}}, 0, 0);

    // Reset while in FINAL discards the message
    feed_word(1, 16'h5555, 1'b1, 1);
    tick();
    check("final_start", bus.core_start_hash, 1'b1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    settle();
    check("mid_rst_core_rst", bus.core_rst, 1'b1);
    check("mid_rst_start", bus.core_start_hash, 1'b0);
    check("mid_rst_dig_valid", bus.dig_valid, 2'b00);
    check("mid_rst_digest", bus.digest, '0);
    tick();
    check("mid_rst_core_rst2", bus.core_rst, 1'b1);
    tick();
    check("mid_rst_idle", bus.core_rst, 1'b0);
    $display("reset in FINAL");
    feed_word(1, 16'h5555, 1'b1, 1);
    finish_hash(1, {8{32'h1234_5678}}, 2, 0);

    // Core stuck busy during absorb
    bus.req_valid[0] = 1'b1; bus.req_data[15:0] = 16'h7777; bus.req_last[0] = 1'b1;
    settle();
    wait_ready(0);
    tick();
    bus.req_valid[0] = 1'b0;
    bus.core_busy = 1'b1;
    settle();
`ifdef SPONGENT_CTRL_TIMEOUT_EN
    for (int k = 1; k < 16; k++) begin
      check("tmo_quiet", bus.error, 1'b0);
      tick();
    end
    check("tmo_error", bus.error, 1'b1);
    check("tmo_no_dig", bus.dig_valid, 2'b00);
    tick();
    check("tmo_error_pulse", bus.error, 1'b0);
    check("tmo_core_rst", bus.core_rst, 1'b1);
    check("tmo_no_dig2", bus.dig_valid, 2'b00);
    bus.core_busy = 1'b0;
    tick(); tick();
    check("tmo_idle", bus.core_rst, 1'b0);
    $display("watchdog abort");
`else
    for (int k = 0; k < 40; k++) tick();
    check("stall_error", bus.error, 1'b0);
    check("stall_core_rst", bus.core_rst, 1'b0);
    check("stall_start", bus.core_start_hash, 1'b0);
    check("stall_data", bus.core_data_input, 16'h7777);
    bus.core_busy = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick(); tick();
    check("stall_recover", bus.core_rst, 1'b0);
    $display("stall held then reset");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
